cdb_arbiter: RTL and testbench

Producer-side driver for the common data bus: collects completed results from the functional units, queues them, and broadcasts them onto the two CDB channels using the bus's rising-edge write-strobe protocol. It sits between the functional-unit writeback ports and the `cdb` block, generating `data`/`write` and `data2`/`write2`. Reservation stations and the register status table observe the result through `cdb`.

---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/cdb_fifo.sv | 51 +++++
 rtl/cdb_arbiter.sv | 127 ++++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter_pkg : word layout and channel state constants for the CDB    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cdb_arbiter_pkg;

  localparam int WORD_W = 64;
  localparam int TAG_HI = 63;
  localparam int TAG_LO = 48;
  localparam int RSV_HI = 47;
  localparam int RSV_LO = 32;
  localparam int VAL_HI = 31;
  localparam int VAL_LO = 0;

  typedef logic [WORD_W-1:0] cdb_word_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;

  // A channel handed a word always (re)enters SETUP, even straight out of STROBE.
  function automatic logic [1:0] ch_next(input logic [1:0] st, input logic give);
    if (give) return ST_SETUP;
    if (st == ST_SETUP) return ST_STROBE;
    return ST_IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_fifo : DEPTH-entry result queue with push, pop, full, empty, head    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  cdb_word_t i_push_data,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output cdb_word_t o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  cdb_word_t   r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter : round-robin FU collector, result queue and CDB strobe FSMs |
// | Define CDB_DUAL_CHANNEL_EN to enable the second channel (data2/write2).  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        req_valid,
  input  logic [NUM_FU*WORD_W-1:0] req_data,
  output logic [NUM_FU-1:0]        req_ready,
  output logic [WORD_W-1:0]        data,
  output logic                     write,
  output logic [WORD_W-1:0]        data2,
  output logic                     write2,
  output logic                     busy
);

  localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [FU_W-1:0] r_ptr;
  logic [FU_W-1:0] w_gidx;
  int              w_idx;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  cdb_word_t       w_sel;
  cdb_word_t       w_push_word;
  cdb_word_t       w_head;
  logic [1:0]      r_st1;
  cdb_word_t       r_data1;
  logic            w_give1;
  logic            w_give2;
  logic            w_ch2_idle;

  // Scan from the highest offset down so the nearest requester at/after r_ptr wins.
  always_comb begin
    w_idx  = 0;
    w_gidx = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_FU) w_idx = w_idx - NUM_FU;
      if (req_valid[w_idx]) w_gidx = FU_W'(w_idx);
    end
  end

  assign req_ready = (|req_valid && !w_full) ? (NUM_FU'(1) << w_gidx) : '0;
  assign w_push    = |req_ready;

  assign w_sel       = req_data[int'(w_gidx)*WORD_W +: WORD_W];
  assign w_push_word = {w_sel[TAG_HI:TAG_LO], w_sel[RSV_HI:RSV_LO], w_sel[VAL_HI:VAL_LO]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_push) begin
      r_ptr <= (int'(w_gidx) == NUM_FU - 1) ? '0 : w_gidx + 1'b1;
    end
  end

  cdb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_word),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  // A channel can take the head unless it is mid-SETUP; channel 1 has priority.
  assign w_give1 = !w_empty && (r_st1 != ST_SETUP);
  assign w_pop   = w_give1 || w_give2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st1   <= ST_IDLE;
      r_data1 <= '0;
    end else begin
      r_st1 <= ch_next(r_st1, w_give1);
      if (w_give1) r_data1 <= w_head;
    end
  end

  assign data  = r_data1;
  assign write = (r_st1 == ST_STROBE);

`ifdef CDB_DUAL_CHANNEL_EN
  logic [1:0] r_st2;
  cdb_word_t  r_data2;

  assign w_give2 = !w_empty && !w_give1 && (r_st2 != ST_SETUP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st2   <= ST_IDLE;
      r_data2 <= '0;
    end else begin
      r_st2 <= ch_next(r_st2, w_give2);
      if (w_give2) r_data2 <= w_head;
    end
  end

  assign data2      = r_data2;
  assign write2     = (r_st2 == ST_STROBE);
  assign w_ch2_idle = (r_st2 == ST_IDLE);
`else
  assign w_give2    = 1'b0;
  assign data2      = '0;
  assign write2     = 1'b0;
  assign w_ch2_idle = 1'b1;
`endif

  assign busy = !w_empty || (r_st1 != ST_IDLE) || !w_ch2_idle;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cdb_arbiter : randomized scoreboard bench for cdb_arbiter             |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_FU = 4;
  localparam int DEPTH  = 4;
`ifdef CDB_DUAL_CHANNEL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_FU-1:0]        req_valid;
  logic [NUM_FU*WORD_W-1:0] req_data;
  logic [NUM_FU-1:0]        req_ready;
  logic [WORD_W-1:0]        data;
  logic                     write;
  logic [WORD_W-1:0]        data2;
  logic                     write2;
  logic                     busy;

  cdb_arbiter #(
    .NUM_FU (NUM_FU),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .data      (data),
    .write     (write),
    .data2     (data2),
    .write2    (write2),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted words, rr pointer, and the edge at which
  // each channel last took a word. A channel is in SETUP right after that edge,
  // in STROBE one cycle later, so it may take a new word unless it just took one.
  typedef struct {
    logic [63:0] word;
    int          ch;
    longint      cyc;
  } exp_t;

  exp_t              exp_q[$];
  logic [63:0]       mq[$];
  int                m_ptr;
  int                m_g;
  longint            ld1;
  longint            ld2;
  logic [NUM_FU-1:0] m_ready;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_ptr = 0;
      ld1   = -10;
      ld2   = -10;
    end else begin
      chk("busy", 64'(busy), 64'((mq.size() > 0) || (ld1 >= cyc - 1) || (ld2 >= cyc - 1)));
      m_g     = -1;
      m_ready = '0;
      if (mq.size() < DEPTH) begin
        for (int k = 0; k < NUM_FU; k++) begin
          if (m_g < 0 && req_valid[(m_ptr + k) % NUM_FU]) m_g = (m_ptr + k) % NUM_FU;
        end
      end
      if (m_g >= 0) m_ready[m_g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(m_ready));
      if (mq.size() > 0) begin
        if (ld1 != cyc) begin
          exp_q.push_back('{word: mq[0], ch: 1, cyc: cyc + 2});
          ld1 = cyc + 1;
          void'(mq.pop_front());
        end else if (DUAL && ld2 != cyc) begin
          exp_q.push_back('{word: mq[0], ch: 2, cyc: cyc + 2});
          ld2 = cyc + 1;
          void'(mq.pop_front());
        end
      end
      if (m_g >= 0) begin
        mq.push_back(req_data[m_g*WORD_W +: WORD_W]);
        m_ptr = (m_g + 1) % NUM_FU;
      end
    end
  end

  // Monitor: every strobe pops the scoreboard.
  logic [63:0] p_d1 = '0;
  logic [63:0] p_d2 = '0;
  logic        p_w1 = 1'b0;
  logic        p_w2 = 1'b0;
  exp_t        e;
  int          n_strobes = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (write && write2) chk("dual_strobe", 64'(write2), 64'd0);
      if (write || write2) begin
        n_strobes++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_ch", write ? 64'd1 : 64'd2, 64'(e.ch));
          chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
          chk("strobe_word", write ? data : data2, e.word);
          chk("strobe_tag", 64'(write ? data[TAG_HI:TAG_LO] : data2[TAG_HI:TAG_LO]),
              64'(e.word[TAG_HI:TAG_LO]));
          chk("data_stable", write ? data : data2, write ? p_d1 : p_d2);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missing_strobe", 64'(exp_q[0].cyc), 64'(cyc));
        void'(exp_q.pop_front());
      end
      if (write && p_w1)  chk("write_consec", 64'(write), 64'd0);
      if (write2 && p_w2) chk("write2_consec", 64'(write2), 64'd0);
      if (!DUAL) begin
        chk("write2_tied", 64'(write2), 64'd0);
        chk("data2_tied", data2, 64'd0);
      end
    end
    p_d1 = data;
    p_d2 = data2;
    p_w1 = write;
    p_w2 = write2;
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, data, 64'd0);
    chk({tag, "_write"}, 64'(write), 64'd0);
    chk({tag, "_data2"}, data2, 64'd0);
    chk({tag, "_write2"}, 64'(write2), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic rand_traffic(input int cycles, input int pct);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        req_valid[i] = ($urandom_range(99) < pct);
        req_data[i*WORD_W +: WORD_W] = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && mq.size() == 0) done = 1'b1;
    end
    chk({tag, "_drained"}, 64'(done), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    req_valid = '0;
    req_data  = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word from FU0.
    req_valid = 4'b0001;
    req_data[0 +: WORD_W] = 64'h0005_0000_0000_002A;
    @(posedge clk);
    #1 req_valid = '0;
    drain("single");

    // Round-robin: every FU requesting continuously, tags 1..4.
    for (int i = 0; i < NUM_FU; i++) begin
      req_data[i*WORD_W +: WORD_W] = {16'(i + 1), 16'h0, 32'h1000_0000 + 32'(i)};
    end
    req_valid = '1;
    repeat (12) @(posedge clk);
    #1 req_valid = '0;
    drain("rr");

    // Heavy back-to-back traffic to push on backpressure.
    rand_traffic(40, 95);
    drain("burst");

    // Random mix for data-stability coverage.
    rand_traffic(150, 50);
    drain("random");
    chk("strobes_seen", 64'(n_strobes > 100), 64'd1);

    // Asynchronous reset while channel 1 strobes.
    req_valid = '1;
    found     = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (write) found = 1'b1;
    end
    chk("strobe_before_reset", 64'(found), 64'd1);
    #1 rst = 1'b1;
    req_valid = '0;
    #1 check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("idle_after_reset_busy", 64'(busy), 64'd0);

    rand_traffic(60, 70);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
